// File: rtl/usb_stream_buf.sv
// Elastic byte buffer between the USB CDC core and the CPU serial ports: independent TX and RX FIFOs.
// Optional RX->TX loopback is compiled in with `define USB_STREAM_BUF_LOOPBACK_EN.
module usb_stream_buf #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
`ifdef USB_STREAM_BUF_LOOPBACK_EN
    input  logic                  loopback_i,
`endif
    input  logic [7:0]            cpu_tx_data_i,
    input  logic                  cpu_tx_valid_i,
    output logic                  cpu_tx_ready_o,
    output logic [7:0]            usb_tx_data_o,
    output logic                  usb_tx_valid_o,
    input  logic                  usb_tx_ready_i,
    input  logic [7:0]            usb_rx_data_i,
    input  logic                  usb_rx_valid_i,
    output logic                  usb_rx_ready_o,
    output logic [7:0]            cpu_rx_data_o,
    output logic                  cpu_rx_valid_o,
    input  logic                  cpu_rx_ready_i,
    output logic [DEPTH_LOG2:0]   tx_level_o,
    output logic [DEPTH_LOG2:0]   rx_level_o
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2:0] ptr_t;
    localparam ptr_t FULL_LEVEL = ptr_t'(DEPTH);
    localparam ptr_t ONE        = ptr_t'(1);

    logic [7:0] tx_mem [DEPTH];
    logic [7:0] rx_mem [DEPTH];
    ptr_t       tx_wr, tx_rd, rx_wr, rx_rd;
    ptr_t       tx_level, rx_level;
    logic       tx_has_room, tx_has_data, rx_has_room, rx_has_data;
    logic       tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0] tx_push_data, tx_head, rx_head;
    logic       lb;

`ifdef USB_STREAM_BUF_LOOPBACK_EN
    assign lb = loopback_i;
`else
    assign lb = 1'b0;
`endif

    assign tx_level    = tx_wr - tx_rd;
    assign rx_level    = rx_wr - rx_rd;
    // Room is gated by rst_i so ready drops the instant reset asserts.
    assign tx_has_room = (tx_level != FULL_LEVEL) && !rst_i;
    assign rx_has_room = (rx_level != FULL_LEVEL) && !rst_i;
    assign tx_has_data = (tx_level != '0);
    assign rx_has_data = (rx_level != '0);
    assign tx_head     = tx_mem[tx_rd[DEPTH_LOG2-1:0]];
    assign rx_head     = rx_mem[rx_rd[DEPTH_LOG2-1:0]];

    always_comb begin
        rx_push      = usb_rx_valid_i && rx_has_room;
        tx_pop       = usb_tx_ready_i && tx_has_data;
        rx_pop       = cpu_rx_ready_i && rx_has_data;
        tx_push      = cpu_tx_valid_i && tx_has_room;
        tx_push_data = cpu_tx_data_i;
        if (lb) begin
            rx_pop       = rx_has_data && tx_has_room;
            tx_push      = rx_pop;
            tx_push_data = rx_head;
        end
    end

    assign cpu_tx_ready_o = tx_has_room && !lb;
    assign usb_tx_valid_o = tx_has_data;
    assign usb_tx_data_o  = tx_has_data ? tx_head : '0;
    assign usb_rx_ready_o = rx_has_room;
    assign cpu_rx_valid_o = rx_has_data && !lb;
    assign cpu_rx_data_o  = rx_has_data ? rx_head : '0;
    assign tx_level_o     = tx_level;
    assign rx_level_o     = rx_level;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_wr <= '0;
            tx_rd <= '0;
            rx_wr <= '0;
            rx_rd <= '0;
        end else if (flush_i) begin
            tx_wr <= '0;
            tx_rd <= '0;
            rx_wr <= '0;
            rx_rd <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + ONE;
            if (tx_pop)  tx_rd <= tx_rd + ONE;
            if (rx_push) rx_wr <= rx_wr + ONE;
            if (rx_pop)  rx_rd <= rx_rd + ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (tx_push && !flush_i) tx_mem[tx_wr[DEPTH_LOG2-1:0]] <= tx_push_data;
        if (rx_push && !flush_i) rx_mem[rx_wr[DEPTH_LOG2-1:0]] <= usb_rx_data_i;
    end

endmodule
